// File: rtl/iecdrv_pkg.sv
// iecdrv_pkg: IEC talker state encoding and default bus timings (microseconds, clk cycles per microsecond)
package iecdrv_pkg;
  typedef enum logic [2:0] {
    IDLE,
    READY,
    EOI_WAIT,
    EOI_ACK,
    BIT_SETUP,
    BIT_VALID,
    FRAME_ACK
  } tx_state_t;
  localparam int unsigned US_CYCLES_DEF  = 32;
  localparam int unsigned T_SETUP_US_DEF = 70;
  localparam int unsigned T_VALID_US_DEF = 20;
  localparam int unsigned T_EOI_US_DEF   = 200;
  localparam int unsigned T_ACK_US_DEF   = 1000;
endpackage

// File: rtl/iecdrv_us_timer.sv
// iecdrv_us_timer: loadable down-counter; ports clk, reset, load, value (reload count), expired (count is zero)
module iecdrv_us_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             expired
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (load) count <= value;
    else if (count != '0) count <= count - WIDTH'(1);
  assign expired = count == '0;
endmodule

// File: rtl/iecdrv_iec_tx.sv
// iecdrv_iec_tx: IEC talker byte transmitter; in: start/din/eoi, synced CLK/DATA/ATN levels; out: CLK/DATA drives (1=release), busy, done/err/abort pulses
module iecdrv_iec_tx
  import iecdrv_pkg::*;
#(
  parameter int unsigned US_CYCLES  = US_CYCLES_DEF,
  parameter int unsigned T_SETUP_US = T_SETUP_US_DEF,
  parameter int unsigned T_VALID_US = T_VALID_US_DEF,
  parameter int unsigned T_EOI_US   = T_EOI_US_DEF,
  parameter int unsigned T_ACK_US   = T_ACK_US_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       eoi,
  input  logic       bus_clk_i,
  input  logic       bus_data_i,
  input  logic       bus_atn_i,
  output logic       bus_clk_o,
  output logic       bus_data_o,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       abort
);
  localparam int TW = $clog2(T_ACK_US * US_CYCLES + 1);
  localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP_US * US_CYCLES - 1);
  localparam logic [TW-1:0] LD_VALID = TW'(T_VALID_US * US_CYCLES - 1);
  localparam logic [TW-1:0] LD_ACK   = TW'(T_ACK_US * US_CYCLES - 1);
  tx_state_t state, state_n;
  logic [7:0] data_q;
  logic [2:0] idx;
  logic eoi_q, hold, expired, load, ev_abort, ev_done, ev_err;
  logic [TW-1:0] load_val;
  logic unused_clk;
  // bit timing is fixed; the CLK line level is not consulted
  assign unused_clk = bus_clk_i;
  iecdrv_us_timer #(.WIDTH(TW)) u_timer (
    .clk(clk),
    .reset(reset),
    .load(load),
    .value(load_val),
    .expired(expired)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      data_q <= '0;
      idx <= '0;
      eoi_q <= 1'b0;
      hold <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      abort <= 1'b0;
    end else begin
      done <= ev_done;
      err <= ev_err;
      abort <= ev_abort;
      if (state == IDLE && state_n == READY) begin
        data_q <= din;
        eoi_q <= eoi;
        idx <= '0;
      end
      if (state == BIT_VALID && state_n == BIT_SETUP) idx <= idx + 3'd1;
      if (ev_done) hold <= 1'b1;
      else if (ev_err || ev_abort || (state == IDLE && !bus_atn_i)) hold <= 1'b0;
    end
  // ATN overrides every other event; start is refused in the abort pulse cycle
  always_comb begin
    state_n = state;
    ev_abort = state != IDLE && !bus_atn_i;
    if (ev_abort) state_n = IDLE;
    else
      case (state)
        IDLE:      state_n = start && !abort ? READY : IDLE;
        READY:     state_n = !bus_data_i ? READY : eoi_q ? EOI_WAIT : BIT_SETUP;
        EOI_WAIT:  state_n = !bus_data_i ? EOI_ACK : expired ? IDLE : EOI_WAIT;
        EOI_ACK:   state_n = bus_data_i ? BIT_SETUP : expired ? IDLE : EOI_ACK;
        BIT_SETUP: state_n = expired ? BIT_VALID : BIT_SETUP;
        BIT_VALID: state_n = !expired ? BIT_VALID : idx == 3'd7 ? FRAME_ACK : BIT_SETUP;
        FRAME_ACK: state_n = !bus_data_i || expired ? IDLE : FRAME_ACK;
        default:   state_n = IDLE;
      endcase
    ev_done = !ev_abort && state == FRAME_ACK && !bus_data_i;
    // any other fall back to IDLE from a busy state is a timeout
    ev_err = !ev_abort && !ev_done && state != IDLE && state_n == IDLE;
    load = state_n != state;
    load_val = state_n == BIT_SETUP ? LD_SETUP : state_n == BIT_VALID ? LD_VALID : LD_ACK;
    busy = state != IDLE;
    bus_clk_o = state == IDLE ? ~hold : !(state == BIT_SETUP || state == FRAME_ACK);
    bus_data_o = state == BIT_SETUP || state == BIT_VALID ? data_q[idx] : 1'b1;
  end
endmodule

// File: tb/tb_iecdrv_iec_tx.sv
// tb_iecdrv_iec_tx: self-checking bench for iecdrv_iec_tx with a scripted listener on the wired DATA line
module tb_iecdrv_iec_tx;
  localparam int US = 4;
  localparam int TS = 70 * US;
  localparam int TV = 20 * US;
  localparam int TA = 1000 * US;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, eoi = 1'b0, atn = 1'b1, lst = 1'b0;
  logic [7:0] din = '0;
  logic bus_clk_o, bus_data_o, busy, done, err, abort, bus_data_i, bus_clk_i;
  int passed = 0, total = 0;
  assign bus_data_i = bus_data_o & lst;
  assign bus_clk_i = bus_clk_o;
  iecdrv_iec_tx #(.US_CYCLES(US)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .din(din),
    .eoi(eoi),
    .bus_clk_i(bus_clk_i),
    .bus_data_i(bus_data_i),
    .bus_atn_i(atn),
    .bus_clk_o(bus_clk_o),
    .bus_data_o(bus_data_o),
    .busy(busy),
    .done(done),
    .err(err),
    .abort(abort)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [7:0] b;
    logic e;
    int rel;
    int eoi_at;
    int eoi_len;
    int ack;
    logic exp_done;
    int exp_t;
    logic exp_clk;
  } vec_t;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got == want) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask
  function automatic void model(input vec_t v, output int t, output logic dn);
    int fs;
    dn = 1'b0;
    if (v.e && v.eoi_at > TA) t = v.rel + 1 + TA;
    else if (v.e && v.eoi_len > TA) t = v.rel + v.eoi_at + 1 + TA;
    else begin
      fs = (v.e ? v.rel + v.eoi_at + v.eoi_len : v.rel) + 1;
      dn = v.ack < TA;
      t = fs + 8 * (TS + TV) + (!dn ? TA : v.ack < 0 ? 1 : v.ack + 1);
    end
  endfunction
  task automatic run_frame(input vec_t v, input string tag);
    int t, fs, f, s8, ev_t, rises, bad_lo, bad_hi, run, multi;
    logic [7:0] got;
    logic [2:0] kind;
    logic prev;
    t = 0; fs = -1; f = -1; s8 = -1; ev_t = -1; rises = 0; bad_lo = 0; bad_hi = 0; run = 0; multi = 0;
    got = '0; kind = '0;
    din = v.b; eoi = v.e; start = 1'b1; lst = 1'b0;
    prev = bus_clk_o;
    while (ev_t < 0 && t < 15000) begin
      tick();
      t++;
      if (t == 1) begin
        start = 1'b0;
        din = ~v.b;
        eoi = ~v.e;
      end
      if (int'(done) + int'(err) + int'(abort) > 1) multi++;
      if (done || err || abort) begin
        ev_t = t;
        kind = {abort, err, done};
      end
      if (fs < 0 && !bus_clk_o) begin
        fs = t;
        run = 1;
      end else if (fs >= 0 && f < 0) begin
        if (bus_clk_o && !prev) begin
          if (rises < 8) got[3'(rises)] = bus_data_i;
          rises++;
          if (run != TS) bad_lo++;
          if (rises == 8) s8 = t;
          run = 1;
        end else if (!bus_clk_o && prev) begin
          if (run != TV) bad_hi++;
          if (rises == 8) f = t;
          run = 1;
        end else run++;
      end
      prev = bus_clk_o;
      lst = !(t < v.rel
              || (v.e && t >= v.rel + v.eoi_at && t < v.rel + v.eoi_at + v.eoi_len)
              || (f >= 0 && t >= f + v.ack)
              || (s8 >= 0 && v.ack < 0 && t >= s8 + TV + v.ack));
    end
    check({tag, " event_time"}, ev_t, v.exp_t);
    check({tag, " event_kind"}, kind, v.exp_done ? 1 : 2);
    check({tag, " multi_pulse"}, multi, 0);
    if (!(v.e && v.eoi_at > TA)) begin
      check({tag, " first_setup"}, fs, (v.e ? v.rel + v.eoi_at + v.eoi_len : v.rel) + 1);
      check({tag, " frame_len"}, f - fs, 8 * (TS + TV));
      check({tag, " bits"}, got, v.b);
      check({tag, " rises"}, rises, 8);
      check({tag, " low_runs_bad"}, bad_lo, 0);
      check({tag, " high_runs_bad"}, bad_hi, 0);
    end else check({tag, " rises"}, rises, 0);
    tick();
    check({tag, " pulse_width"}, {abort, err, done}, 0);
    check({tag, " clk_after"}, bus_clk_o, v.exp_clk);
    check({tag, " data_after"}, bus_data_o, 1);
    check({tag, " busy_after"}, busy, 0);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, %0d/%0d", passed, total);
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t tbl[6];
    tbl[0] = '{8'hA5, 1'b0, 10, 1, 1, 40, 1'b1, 2932, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 10, 800, 240, 5, 1'b1, 3937, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 5, 100000, 1, 0, 1'b0, 4006, 1'b1};
    tbl[3] = '{8'h5A, 1'b0, 3, 1, 1, 100000, 1'b0, 6884, 1'b1};
    tbl[4] = '{8'hFF, 1'b0, 1, 1, 1, -5, 1'b1, 2883, 1'b0};
    tbl[5] = '{8'h00, 1'b0, 1, 1, 1, 3998, 1'b1, 6881, 1'b0};
    tick();
    tick();
    check("reset clk", bus_clk_o, 1);
    check("reset data", bus_data_o, 1);
    check("reset busy", busy, 0);
    check("reset pulses", {abort, err, done}, 0);
    reset = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) run_frame(tbl[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 6; i++) begin
      vec_t v;
      v.b = 8'($urandom);
      v.e = 1'($urandom_range(0, 1));
      v.rel = $urandom_range(1, 20);
      v.eoi_at = $urandom_range(1, 60);
      v.eoi_len = $urandom_range(1, 60);
      v.ack = int'($urandom_range(0, 65)) - 5;
      model(v, v.exp_t, v.exp_done);
      v.exp_clk = !v.exp_done;
      run_frame(v, $sformatf("rnd%0d", i));
    end
    check("idle hold clk", bus_clk_o, 0);
    atn = 1'b0;
    tick();
    check("idle atn clk", bus_clk_o, 1);
    check("idle atn pulse", abort, 0);
    atn = 1'b1;
    din = 8'hA5; eoi = 1'b0; lst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; lst = 1'b1;
    repeat (1090) tick();
    check("atn pre clk", bus_clk_o, 0);
    check("atn pre data", bus_data_o, 0);
    atn = 1'b0; start = 1'b1;
    tick();
    check("atn abort", abort, 1);
    check("atn clk", bus_clk_o, 1);
    check("atn data", bus_data_o, 1);
    check("atn busy", busy, 0);
    check("atn others", {err, done}, 0);
    atn = 1'b1;
    tick();
    check("atn start ignored", busy, 0);
    check("atn pulse width", abort, 0);
    start = 1'b0;
    tick();
    din = 8'h96; lst = 1'b0; start = 1'b1;
    tick();
    start = 1'b0; lst = 1'b1;
    repeat (300) tick();
    check("rst pre clk", bus_clk_o, 1);
    check("rst pre data", bus_data_o, 0);
    #2 reset = 1'b1;
    #1;
    check("rst async clk", bus_clk_o, 1);
    check("rst async data", bus_data_o, 1);
    check("rst async busy", busy, 0);
    check("rst async pulses", {abort, err, done}, 0);
    tick();
    reset = 1'b0;
    run_frame('{8'h96, 1'b0, 2, 1, 1, 7, 1'b1, 2891, 1'b0}, "after_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
